// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled UART receiver with majority vote,
// parity/stop/break checks and a show-ahead frame FIFO.
module uart_rx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int DIV_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        uart_rxd,
    input  logic                        rx_en,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [PAYLOAD_BITS-1:0]     m_data,
    output logic                        m_perr,
    output logic                        m_ferr,
    output logic                        m_brk,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overrun,
    input  logic                        ovr_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = PAYLOAD_BITS + 3;
    localparam logic [3:0] LAST_BIT = 4'(PAYLOAD_BITS - 1);
    localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH
    } state_t;

    state_t state_q, state_d;

    logic sync1, sync2, rxs;
    logic [DIV_W-1:0] div_q, div_cnt;
    logic [1:0] par_q;
    logic stop2_q;
    logic [3:0] smp_cnt, bit_idx;
    logic s7, s8, bit_v, par_bit, stop1_bit;
    logic [PAYLOAD_BITS-1:0] shreg;

    logic tick, at9, at15, vote_now, par_en, stop1_v;
    logic done, ferr_c, perr_c, brk_c, wr_en;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic full, push, pop;
    logic [EW-1:0] head;

    // Disabled receiver parks the line high so no start is seen.
    always_ff @(posedge clk) begin
        if (!rst_n || !rx_en) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
        end
    end

    assign rxs = sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!rx_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:      if (!rxs) state_d = START;
                START:     if (at15) state_d = bit_v ? IDLE : DATA;
                DATA: begin
                    if (at15 && bit_idx == LAST_BIT)
                        state_d = par_en ? PARITY : STOP1;
                end
                PARITY:    if (at15) state_d = STOP1;
                STOP1: begin
                    if (stop2_q) begin
                        if (at15) state_d = STOP2;
                    end else if (done) begin
                        state_d = ferr_c ? WAIT_HIGH : IDLE;
                    end
                end
                STOP2:     if (done) state_d = ferr_c ? WAIT_HIGH : IDLE;
                WAIT_HIGH: if (rxs) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        par_en   = ^par_q;
        tick     = (state_q != IDLE) && (state_q != WAIT_HIGH)
                   && (div_cnt == div_q);
        at9      = tick && (smp_cnt == 4'd9);
        at15     = tick && (smp_cnt == 4'd15);
        vote_now = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
        stop1_v  = (state_q == STOP2) ? stop1_bit : vote_now;
        done     = at9 && ((state_q == STOP1 && !stop2_q)
                   || state_q == STOP2);
        ferr_c   = !stop1_v || (state_q == STOP2 && !vote_now);
        brk_c    = (shreg == '0) && !(par_en && par_bit) && !stop1_v;
        perr_c   = par_en && ((^shreg) ^ par_bit ^ par_q[1]);
        wr_en    = done && rx_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q     <= '0;
            par_q     <= '0;
            stop2_q   <= 1'b0;
            div_cnt   <= '0;
            smp_cnt   <= '0;
            bit_idx   <= '0;
            s7        <= 1'b1;
            s8        <= 1'b1;
            bit_v     <= 1'b1;
            par_bit   <= 1'b0;
            stop1_bit <= 1'b1;
            shreg     <= '0;
        end else begin
            if (state_q == IDLE || state_q == WAIT_HIGH) begin
                div_cnt <= '0;
                smp_cnt <= '0;
            end else if (tick) begin
                div_cnt <= '0;
                smp_cnt <= smp_cnt + 4'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (state_q == IDLE && !rxs) begin
                div_q   <= cfg_div;
                par_q   <= cfg_parity;
                stop2_q <= cfg_stop2;
                bit_idx <= '0;
            end
            if (tick && smp_cnt == 4'd7) s7 <= rxs;
            if (tick && smp_cnt == 4'd8) s8 <= rxs;
            if (at9) bit_v <= vote_now;
            if (at15 && state_q == DATA) begin
                shreg   <= {bit_v, shreg[PAYLOAD_BITS-1:1]};
                bit_idx <= bit_idx + 4'd1;
            end
            if (at15 && state_q == PARITY) par_bit <= bit_v;
            if (at15 && state_q == STOP1) stop1_bit <= bit_v;
        end
    end

    assign full    = (fifo_level == DEPTH_L);
    assign m_valid = (fifo_level != '0);
    assign pop     = m_valid && m_ready;
    // A pop in the same cycle frees the slot being written.
    assign push    = wr_en && (!full || pop);
    assign head    = mem[rd_ptr];
    assign {m_brk, m_ferr, m_perr, m_data} = m_valid ? head : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {brk_c, ferr_c, perr_c, shreg};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overrun    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_level <= fifo_level + 1'b1;
            else if (pop && !push) fifo_level <= fifo_level - 1'b1;
            if (wr_en && full && !pop) overrun <= 1'b1;
            else if (ovr_clr)          overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames with a queue scoreboard
// checked by an independent FIFO-drain monitor.
module tb_uart_rx_fifo;

    localparam int PB = 8;
    localparam int FD = 4;
    localparam int DW = 16;
    localparam int ST_IDLE = 0;
    localparam int ST_WAIT_HIGH = 6;

    logic clk = 1'b0;
    logic rst_n, uart_rxd, rx_en, cfg_stop2;
    logic m_valid, m_ready, m_perr, m_ferr, m_brk;
    logic overrun, ovr_clr;
    logic [DW-1:0] cfg_div;
    logic [1:0] cfg_parity;
    logic [PB-1:0] m_data;
    logic [$clog2(FD):0] fifo_level;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [PB+2:0] exp_q [$];
    logic [PB+2:0] got, want;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .PAYLOAD_BITS(PB),
        .FIFO_DEPTH(FD),
        .DIV_W(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart_rxd(uart_rxd),
        .rx_en(rx_en),
        .cfg_div(cfg_div),
        .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_perr(m_perr),
        .m_ferr(m_ferr),
        .m_brk(m_brk),
        .fifo_level(fifo_level),
        .overrun(overrun),
        .ovr_clr(ovr_clr)
    );

    function automatic logic [PB+2:0] ent(input logic b, input logic f,
                                          input logic p,
                                          input logic [PB-1:0] d);
        return {b, f, p, d};
    endfunction

    task automatic chk(input string name, input int g, input int e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, g, e);
        end
    endtask

    // Each accepted head is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            got = {m_brk, m_ferr, m_perr, m_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_entry got=%0h", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL entry got=%0h exp=%0h", got, want);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // pmode: -1 no parity bit, else the parity bit to send.
    // gbit: frame bit carrying a 1-clock inverted glitch, or -1.
    task automatic send_frame(input logic [7:0] d, input int div,
                              input int pmode, input logic st1,
                              input int nstop, input logic st2,
                              input int gbit);
        int bt;
        int n;
        logic [11:0] bits;
        bt = 16 * (div + 1);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (pmode >= 0) begin
            bits[n] = pmode[0];
            n++;
        end
        bits[n] = st1;
        n++;
        if (nstop == 2) begin
            bits[n] = st2;
            n++;
        end
        for (int k = 0; k < n; k++) begin
            uart_rxd = bits[k];
            if (k == gbit) begin
                idle(9);
                uart_rxd = ~bits[k];
                idle(1);
                uart_rxd = bits[k];
                idle(bt - 10);
            end else begin
                idle(bt);
            end
        end
        uart_rxd = 1'b1;
    endtask

    task automatic meas_lat(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!m_valid && n < 400);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 3000) begin
            idle(1);
            i++;
        end
        chk("drain", exp_q.size(), 0);
        idle(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        uart_rxd = 1'b1;
        rx_en = 1'b1;
        cfg_div = '0;
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        m_ready = 1'b1;
        ovr_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_flags", {m_brk, m_ferr, m_perr}, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_state", int'(dut.state_q), ST_IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        exp_q.push_back(ent(0, 0, 0, 8'hA5));
        fork
            send_frame(8'hA5, 0, -1, 1, 1, 1, -1);
            meas_lat(lat);
        join
        chk("lat_8n1", lat, 157);
        idle(32);
        drain();

        cfg_parity = 2'b01;
        exp_q.push_back(ent(0, 0, 0, 8'h07));
        send_frame(8'h07, 0, 1, 1, 1, 1, -1);
        idle(32);
        exp_q.push_back(ent(0, 0, 1, 8'h07));
        send_frame(8'h07, 0, 0, 1, 1, 1, -1);
        idle(32);
        cfg_parity = 2'b10;
        exp_q.push_back(ent(0, 0, 0, 8'h07));
        send_frame(8'h07, 0, 0, 1, 1, 1, -1);
        idle(32);
        drain();

        cfg_parity = 2'b00;
        exp_q.push_back(ent(0, 0, 0, 8'h3B));
        fork
            send_frame(8'h3B, 0, -1, 1, 1, 1, -1);
            begin
                idle(48);
                cfg_parity = 2'b10;
            end
        join
        idle(32);
        cfg_parity = 2'b00;
        drain();

        uart_rxd = 1'b0;
        idle(3);
        uart_rxd = 1'b1;
        idle(48);
        chk("glitch_level", fifo_level, 0);
        chk("glitch_state", int'(dut.state_q), ST_IDLE);

        exp_q.push_back(ent(0, 0, 0, 8'h5A));
        send_frame(8'h5A, 0, -1, 1, 1, 1, 4);
        idle(32);
        drain();

        cfg_div = 16'd3;
        exp_q.push_back(ent(1, 1, 0, 8'h00));
        uart_rxd = 1'b0;
        idle(20 * 64);
        uart_rxd = 1'b1;
        idle(128);
        exp_q.push_back(ent(0, 0, 0, 8'h55));
        send_frame(8'h55, 3, -1, 1, 1, 1, -1);
        idle(128);
        drain();
        chk("brk_level", fifo_level, 0);
        cfg_div = '0;

        m_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 0, -1, 1, 1, 1, -1);
            idle(16);
        end
        chk("ovr_level", fifo_level, 4);
        chk("ovr_flag", overrun, 1);
        ovr_clr = 1'b1;
        idle(1);
        ovr_clr = 1'b0;
        chk("ovr_clr", overrun, 0);
        for (int k = 1; k <= 4; k++) exp_q.push_back(ent(0, 0, 0, 8'(k)));
        m_ready = 1'b1;
        drain();
        chk("ovr_drained", fifo_level, 0);

        fork
            send_frame(8'h96, 0, -1, 1, 1, 1, -1);
            begin
                idle(88);
                rx_en = 1'b0;
                idle(1);
                chk("abort_state", int'(dut.state_q), ST_IDLE);
            end
        join
        idle(16);
        rx_en = 1'b1;
        idle(32);
        chk("abort_level", fifo_level, 0);

        cfg_stop2 = 1'b1;
        exp_q.push_back(ent(0, 1, 0, 8'h3C));
        send_frame(8'h3C, 0, -1, 1, 2, 0, -1);
        uart_rxd = 1'b0;
        idle(48);
        chk("wait_high", int'(dut.state_q), ST_WAIT_HIGH);
        uart_rxd = 1'b1;
        idle(6);
        chk("wait_release", int'(dut.state_q), ST_IDLE);
        exp_q.push_back(ent(0, 0, 0, 8'hC3));
        send_frame(8'hC3, 0, -1, 1, 2, 1, -1);
        idle(32);
        drain();
        cfg_stop2 = 1'b0;

        chk("leftover", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
